// File: rtl/bit_transmitter_pkg.sv
// Shared constants and types for the counter-gated serial bit transmitter.
package bit_transmitter_pkg;

  localparam int unsigned CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = 8'hFF;
  localparam cnt_t CNT_RST = 8'h00;

  function automatic logic is_terminal(input cnt_t value);
    return value == CNT_MAX;
  endfunction

endpackage

// File: rtl/bit_transmitter_if.sv
// Control, data and status signals between a serial source and the transmitter.
interface bit_transmitter_if;
  import bit_transmitter_pkg::*;

  logic load;
  logic cnt_8_en;
  cnt_t parin_8_cnt;
  logic serIn;
  logic serOut;
  logic cout;
  cnt_t parout_8_cnt;

  modport master (
    output load, cnt_8_en, parin_8_cnt, serIn,
    input  serOut, cout, parout_8_cnt
  );

  modport slave (
    input  load, cnt_8_en, parin_8_cnt, serIn,
    output serOut, cout, parout_8_cnt
  );

endinterface

// File: rtl/bit_transmitter_counter.sv
// 8-bit loadable up-counter that saturates at its terminal value.
module up_counter_8
  import bit_transmitter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  cnt_t parin,
  output cnt_t parout,
  output logic co
);

  cnt_t count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= CNT_RST;
    end else if (load) begin
      count <= parin;
    end else if (en && !is_terminal(count)) begin
      count <= count + cnt_t'(1);
    end
  end

  assign parout = count;
  assign co     = is_terminal(count);

endmodule

// File: rtl/bit_transmitter.sv
// Passes serial bits straight through while the counter window is open.
module bit_transmitter
  import bit_transmitter_pkg::*;
(
  input logic              clk,
  input logic              rst,
  bit_transmitter_if.slave bus
);

  cnt_t count;
  logic co;
  logic active;

  up_counter_8 u_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (bus.load),
    .en     (bus.cnt_8_en),
    .parin  (bus.parin_8_cnt),
    .parout (count),
    .co     (co)
  );

  // Window is judged on the registered count, so load does not gate serOut.
  assign active           = bus.cnt_8_en && !co;
  assign bus.serOut       = active ? bus.serIn : 1'b0;
  assign bus.cout         = co;
  assign bus.parout_8_cnt = count;

endmodule

// File: tb/tb_bit_transmitter.sv
// Directed-vector scoreboard bench for bit_transmitter.
module tb_bit_transmitter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bit_transmitter_if bus ();

  bit_transmitter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       load;
    logic       en;
    logic [7:0] par;
    logic       si;
    logic [7:0] cnt;
    logic       co;
    logic       so;
  } vec_t;

  typedef struct {
    int unsigned idx;
    logic [7:0]  cnt;
    logic        co;
    logic        so;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  logic drv_done = 1'b0;

  function automatic vec_t mk(input logic r, input logic l, input logic e,
                              input logic [7:0] p, input logic s,
                              input logic [7:0] c, input logic co, input logic so);
    vec_t v;
    v.rst = r; v.load = l; v.en = e; v.par = p; v.si = s;
    v.cnt = c; v.co = co; v.so = so;
    return v;
  endfunction

  // Expected values are the outputs seen during the cycle the inputs are held,
  // i.e. before the next rising edge commits them.
  initial begin
    //          rst ld en  par    si  cnt    co so
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 0)); // reset state, en low
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h03, 0, 8'h00, 0, 0)); // load 03
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'h03, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h04, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'h05, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'h06, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h07, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'h08, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'hFD, 1, 8'h09, 0, 0)); // reached 09, load FD
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'hFD, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'hFE, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'hFF, 1, 0)); // terminal, saturates
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'hFF, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'h10, 1, 8'hFF, 1, 0)); // load+en at FF
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h10, 0, 0)); // 10 not 11
    vecs.push_back(mk(0, 1, 1, 8'h20, 1, 8'h10, 0, 1)); // load+en, serOut passes
    vecs.push_back(mk(0, 1, 1, 8'hFF, 1, 8'h20, 0, 1)); // load FF
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'hFF, 1, 0)); // zero-length window
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 8'hFF, 1, 0)); // load 00
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'h00, 0, 1)); // transmission resumes
    vecs.push_back(mk(0, 1, 0, 8'h3E, 0, 8'h01, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'h3E, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h3F, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h40, 0, 0)); // enable dropped at 40
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h40, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'h40, 0, 1)); // resume from 40
    vecs.push_back(mk(1, 0, 1, 8'h00, 1, 8'h41, 0, 1)); // rst while enabled
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'h01, 0, 1));
  end

  // Driver
  initial begin
    exp_t e;
    bus.load = 1'b0;
    bus.cnt_8_en = 1'b0;
    bus.parin_8_cnt = 8'h00;
    bus.serIn = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    foreach (vecs[i]) begin
      rst             = vecs[i].rst;
      bus.load        = vecs[i].load;
      bus.cnt_8_en    = vecs[i].en;
      bus.parin_8_cnt = vecs[i].par;
      bus.serIn       = vecs[i].si;
      e.idx = i;
      e.cnt = vecs[i].cnt;
      e.co  = vecs[i].co;
      e.so  = vecs[i].so;
      exp_q.push_back(e);
      n_vec++;
      @(negedge clk);
    end
    drv_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
      n_miss++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Monitor: samples mid-low-phase, after inputs have settled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (bus.parout_8_cnt !== e.cnt) begin
          $display("FAIL count[%0d]: got=%h required=%h", e.idx, bus.parout_8_cnt, e.cnt);
          n_miss++;
        end
        if (bus.cout !== e.co) begin
          $display("FAIL cout[%0d]: got=%b required=%b", e.idx, bus.cout, e.co);
          n_miss++;
        end
        if (bus.serOut !== e.so) begin
          $display("FAIL serOut[%0d]: got=%b required=%b", e.idx, bus.serOut, e.so);
          n_miss++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: drv_done=%b required=1", drv_done);
    $fatal(1, "timeout");
  end

endmodule
